// File: rtl/fakeram_1rw1r_ctrl.sv
// Requester-side controller for a 1rw1r SRAM macro: port A (read/write) drives rw0, port B (read-only) drives r0.
// Optional post-reset zero-fill, credit-based response buffering and A-write/B-read collision stall.

module fakeram_rsp_fifo #(
    parameter int BITS = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rd_accept,
    input  logic [BITS-1:0] rd_out,
    input  logic            rsp_ready,
    output logic            rsp_valid,
    output logic [BITS-1:0] rsp_rdata,
    output logic            credit_ok
);
    logic            inflight_q;
    logic [1:0]      count_q;
    logic [1:0]      count_d;
    logic            wr_ptr_q;
    logic            rd_ptr_q;
    logic [BITS-1:0] mem_q [2];
    logic            pop;
    logic [2:0]      used;

    assign rsp_valid = (count_q != 2'd0);
    assign rsp_rdata = mem_q[rd_ptr_q];
    assign pop       = rsp_valid && rsp_ready;
    // Slots committed for next cycle; a pop this cycle frees one immediately.
    assign used      = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign credit_ok = (used < 3'd2);
    assign count_d   = count_q + {1'b0, inflight_q} - {1'b0, pop};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
        end else begin
            inflight_q <= rd_accept;
            count_q    <= count_d;
            if (inflight_q) wr_ptr_q <= ~wr_ptr_q;
            if (pop)        rd_ptr_q <= ~rd_ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (inflight_q) mem_q[wr_ptr_q] <= rd_out;
    end
endmodule

module fakeram_1rw1r_ctrl #(
    parameter int BITS          = 64,
    parameter int WORD_DEPTH    = 1024,
    parameter int ADDR_WIDTH    = 10,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    output logic                  init_done,
    input  logic                  a_req_valid,
    output logic                  a_req_ready,
    input  logic                  a_req_we,
    input  logic [ADDR_WIDTH-1:0] a_req_addr,
    input  logic [BITS-1:0]       a_req_wdata,
    output logic                  a_rsp_valid,
    input  logic                  a_rsp_ready,
    output logic [BITS-1:0]       a_rsp_rdata,
    input  logic                  b_req_valid,
    output logic                  b_req_ready,
    input  logic [ADDR_WIDTH-1:0] b_req_addr,
    output logic                  b_rsp_valid,
    input  logic                  b_rsp_ready,
    output logic [BITS-1:0]       b_rsp_rdata,
    output logic                  rw0_ce_in,
    output logic                  rw0_we_in,
    output logic [ADDR_WIDTH-1:0] rw0_addr_in,
    output logic [BITS-1:0]       rw0_wd_in,
    input  logic [BITS-1:0]       rw0_rd_out,
    output logic                  r0_ce_in,
    output logic [ADDR_WIDTH-1:0] r0_addr_in,
    input  logic [BITS-1:0]       r0_rd_out
);
    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic                  init_done_q;

    logic run, filling;
    logic a_credit, b_credit;
    logic a_acc, a_wr_acc, b_acc;

    assign run       = (state_q == ST_RUN);
    assign filling   = (state_q == ST_INIT) && INIT_ON_RESET;
    assign init_done = init_done_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (!INIT_ON_RESET || cnt_q == ADDR_WIDTH'(WORD_DEPTH - 1)) begin
                        state_q     <= ST_RUN;
                        init_done_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign a_req_ready = run && a_credit;
    assign a_acc       = a_req_valid && a_req_ready;
    assign a_wr_acc    = a_acc && a_req_we;
    // A write and B read to the same word: hold B off so it sees the new data.
    assign b_req_ready = run && b_credit && !(a_wr_acc && (b_req_addr == a_req_addr));
    assign b_acc       = b_req_valid && b_req_ready;

    // Macro pins are forced quiet while reset is asserted, even mid-fill.
    assign rw0_ce_in   = sys_rst_n && (filling || a_acc);
    assign rw0_we_in   = sys_rst_n && (filling || a_wr_acc);
    assign rw0_addr_in = !sys_rst_n ? '0 : (filling ? cnt_q : a_req_addr);
    assign rw0_wd_in   = (!sys_rst_n || filling) ? '0 : a_req_wdata;
    assign r0_ce_in    = b_acc;
    assign r0_addr_in  = sys_rst_n ? b_req_addr : '0;

    fakeram_rsp_fifo #(.BITS(BITS)) u_a_fifo (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .rd_accept (a_acc && !a_req_we),
        .rd_out    (rw0_rd_out),
        .rsp_ready (a_rsp_ready),
        .rsp_valid (a_rsp_valid),
        .rsp_rdata (a_rsp_rdata),
        .credit_ok (a_credit)
    );

    fakeram_rsp_fifo #(.BITS(BITS)) u_b_fifo (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .rd_accept (b_acc),
        .rd_out    (r0_rd_out),
        .rsp_ready (b_rsp_ready),
        .rsp_valid (b_rsp_valid),
        .rsp_rdata (b_rsp_rdata),
        .credit_ok (b_credit)
    );
endmodule
